// File: rtl/ipm_distributed_fifo_v1_3_audio_pkt.sv
// Single-clock distributed-RAM FIFO for audio sample packets, STANDARD or FWFT read mode.
// Optional registered overflow/underflow pulses are built when FIFO_ERR_FLAG_EN is defined.
module ipm_distributed_fifo_v1_3_audio_pkt #(
   parameter int unsigned ADDR_WIDTH       = 4,
   parameter int unsigned DATA_WIDTH       = 16,
   parameter string       RD_MODE          = "STANDARD",
   parameter int unsigned ALMOST_FULL_NUM  = 2**ADDR_WIDTH - 2,
   parameter int unsigned ALMOST_EMPTY_NUM = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   wr_water_level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
   localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);
   localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH+1)'(1);

   generate
      if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10) begin : g_bad_addr
         $error("ADDR_WIDTH out of range 4..10");
      end
      if (DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_bad_data
         $error("DATA_WIDTH out of range 1..256");
      end
      if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH) begin : g_bad_af
         $error("ALMOST_FULL_NUM out of range 1..DEPTH");
      end
      if (ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_bad_ae
         $error("ALMOST_EMPTY_NUM out of range 0..DEPTH-1");
      end
      if (RD_MODE != "STANDARD" && RD_MODE != "FWFT") begin : g_bad_mode
         $error("RD_MODE must be STANDARD or FWFT");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic [ADDR_WIDTH:0]   ptr_gap;
   logic [DATA_WIDTH-1:0] head;
   logic                  wr_acc;
   logic                  rd_acc;

   // Accept decisions look only at the registered count, so a full FIFO refuses a
   // write even when a read frees a slot in the same cycle (and vice versa for empty).
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
      end
   end

   assign head = mem[rd_ptr[ADDR_WIDTH-1:0]];

   always_comb begin
      count_nxt = count;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + ONE_CNT;
         2'b01:   count_nxt = count - ONE_CNT;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + ONE_CNT;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + ONE_CNT;
         end
         count <= count_nxt;
      end
   end

   assign full           = (count == DEPTH_CNT);
   assign empty          = (count == '0);
   assign almost_full    = (count >= AF_CNT);
   assign almost_empty   = (count <= AE_CNT);
   assign wr_water_level = count;

   // The separate count register must always agree with the pointer distance.
   assign ptr_gap = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (ptr_gap == count);
      end
   end

   generate
      if (RD_MODE == "FWFT") begin : g_fwft
         assign rd_data = head;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rd_data_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data_q <= '0;
            end else if (rd_acc) begin
               rd_data_q <= head;
            end
         end

         assign rd_data = rd_data_q;
      end
   endgenerate

`ifdef FIFO_ERR_FLAG_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= wr_en & full;
         underflow_q <= rd_en & empty;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ipm_distributed_fifo_v1_3_audio_pkt.sv
// Self-checking bench: a STANDARD and an FWFT instance share stimulus and are compared
// against a queue-based reference model, with directed and randomized phases.
module tb_ipm_distributed_fifo_v1_3_audio_pkt;

   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;
`ifdef FIFO_ERR_FLAG_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [15:0] wr_data;

   logic [15:0] s_rd_data, f_rd_data;
   logic        s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
   logic        f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
   logic [4:0]  s_level, f_level;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [15:0] q[$];
   logic [15:0] exp_rd;
   logic        exp_ovf;
   logic        exp_udf;

   ipm_distributed_fifo_v1_3_audio_pkt #(
      .ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_MODE("STANDARD"),
      .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
   ) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(s_rd_data), .full(s_full), .empty(s_empty), .almost_full(s_afull),
      .almost_empty(s_aempty), .wr_water_level(s_level), .overflow(s_ovf),
      .underflow(s_udf)
   );

   ipm_distributed_fifo_v1_3_audio_pkt #(
      .ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_MODE("FWFT"),
      .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
   ) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(f_rd_data), .full(f_full), .empty(f_empty), .almost_full(f_afull),
      .almost_empty(f_aempty), .wr_water_level(f_level), .overflow(f_ovf),
      .underflow(f_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int n = q.size();
      check("std_rd_data",  32'(s_rd_data), 32'(exp_rd));
      check("std_empty",    32'(s_empty),   32'(n == 0));
      check("std_full",     32'(s_full),    32'(n == DEPTH));
      check("std_afull",    32'(s_afull),   32'(n >= AF));
      check("std_aempty",   32'(s_aempty),  32'(n <= AE));
      check("std_level",    32'(s_level),   32'(n));
      check("std_overflow", 32'(s_ovf),     32'(exp_ovf));
      check("std_underflw", 32'(s_udf),     32'(exp_udf));
      check("fwft_empty",   32'(f_empty),   32'(n == 0));
      check("fwft_level",   32'(f_level),   32'(n));
      check("fwft_overflw", 32'(f_ovf),     32'(exp_ovf));
      if (n != 0) begin
         check("fwft_rd_data", 32'(f_rd_data), 32'(q[0]));
      end
   endtask

   // Called at a falling edge: check settled outputs, apply inputs, advance the model,
   // then wait for the next falling edge (the rising edge in between commits them).
   task automatic step(input logic w, input logic r, input logic [15:0] d);
      bit was_full, was_empty;
      check_outputs();
      wr_en   = w;
      rd_en   = r;
      wr_data = d;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      exp_ovf = ERR_EN & w & was_full;
      exp_udf = ERR_EN & r & was_empty;
      if (r && !was_empty) exp_rd = q.pop_front();
      if (w && !was_full)  q.push_back(d);
      @(negedge clk);
   endtask

   task automatic model_reset();
      q.delete();
      exp_rd  = '0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      wr_data = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Fill 16 words, then an extra write into a full FIFO
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'(i));
      step(1'b1, 1'b0, 16'hDEAD);
      step(1'b0, 1'b0, 16'h0);

      // Drain 16 words, then an extra read of an empty FIFO
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0);
      step(1'b0, 1'b1, 16'h0);
      step(1'b0, 1'b0, 16'h0);

      // Single FWFT word appears without rd_en, then is popped
      step(1'b1, 1'b0, 16'hA5A5);
      step(1'b0, 1'b0, 16'h0);
      check("fwft_a5a5", 32'(f_rd_data), 32'h0000_A5A5);
      step(1'b0, 1'b1, 16'h0);
      step(1'b0, 1'b0, 16'h0);

      // Simultaneous read and write at full and at empty
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h100 + 16'(i));
      step(1'b1, 1'b1, 16'hBEEF);
      step(1'b0, 1'b0, 16'h0);
      while (q.size() != 0) step(1'b0, 1'b1, 16'h0);
      step(1'b1, 1'b1, 16'hCAFE);
      step(1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b1, 16'h0);

      // Wrap: hold count at 5 over 40 concurrent read/write cycles
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h200 + 16'(i));
      for (int i = 5; i < 45; i++) step(1'b1, 1'b1, 16'h200 + 16'(i));
      while (q.size() != 0) step(1'b0, 1'b1, 16'h0);

      // Randomized phases alternately biased toward filling and draining
      for (int i = 0; i < 400; i++) begin
         int pw = ((i / 50) % 2 == 0) ? 75 : 30;
         step(32'($urandom_range(99)) < 32'(pw), 32'($urandom_range(99)) < 32'(100 - pw),
              16'($urandom));
      end

      // Asynchronous reset at count 9, between edges
      while (q.size() != 0) step(1'b0, 1'b1, 16'h0);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 16'h300 + 16'(i));
      check_outputs();
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_empty", 32'(s_empty), 32'd1);
      check("rst_level", 32'(s_level), 32'd0);
      check("rst_rddata", 32'(s_rd_data), 32'd0);
      check("rst_fwft_empty", 32'(f_empty), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      step(1'b1, 1'b0, 16'h1234);
      step(1'b0, 1'b1, 16'h0);
      step(1'b0, 1'b0, 16'h0);
      check("post_rst_read", 32'(s_rd_data), 32'h0000_1234);
      check_outputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ipm_distributed_fifo_v1_3_audio_pkt.md
# ipm_distributed_fifo_v1_3_audio_pkt

Single-clock FIFO built on distributed (LUT) RAM for buffering audio sample packets between the FFT/FIR datapath and the UDP packetiser. It generalises the distributed SDP RAM primitive into a complete FIFO: pointer management, full/empty, programmable almost-full/almost-empty thresholds, a fill-level count, and a selectable standard or first-word-fall-through (FWFT) read mode.

## Interface
- ADDR_WIDTH, 4: depth is 2**ADDR_WIDTH words; legal range 4–10.
- DATA_WIDTH, 16: word width; legal range 1–256.
- RD_MODE, "STANDARD": "STANDARD" (data one cycle after rd_en) or "FWFT" (head word presented while not empty).
- ALMOST_FULL_NUM, 2**ADDR_WIDTH-2: almost_full asserts when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_NUM, 2: almost_empty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write word.
- rd_en  input  1  read request (STANDARD) / pop head (FWFT).
- rd_data  output  DATA_WIDTH  read word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= ALMOST_FULL_NUM.
- almost_empty  output  1  count <= ALMOST_EMPTY_NUM.
- wr_water_level  output  ADDR_WIDTH+1  current count, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write refused (see Configuration).
- underflow  output  1  one-cycle pulse: read refused (see Configuration).

## Operation
- Storage: DEPTH x DATA_WIDTH array, written synchronously, read asynchronously at rd_ptr[ADDR_WIDTH-1:0]. Contents are not reset.
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits and wrap modulo 2**(ADDR_WIDTH+1). The low bits address the RAM. count is held as a separate ADDR_WIDTH+1-bit register.
- Write accepted (wr_acc) = wr_en & ~full. A write is refused when full, even if a read is accepted in the same cycle.
- Read accepted (rd_acc) = rd_en & ~empty. A read is refused when empty, even if a write is accepted in the same cycle.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Flags are combinational decodes of the registered count. No flag decodes pointer equality.
- STANDARD mode: rd_data is a register. On rd_acc it loads mem[rd_ptr]; otherwise it holds its value.
- FWFT mode: rd_data = mem[rd_ptr] combinationally. The value is valid whenever empty=0, and rd_en pops the word shown.
- Reset (asynchronous, any time, including mid-burst): wr_ptr=0, rd_ptr=0, count=0, rd_data register=0, overflow=0, underflow=0. This gives empty=1, full=0, almost_empty=1, almost_full=0 and wr_water_level=0. In FWFT mode rd_data after reset is whatever the RAM holds at address 0, and is don't-care while empty=1.

## Timing
- Write to flags: a write at edge N updates count, empty, almost_* and full after edge N.
- Write to read: a word written at edge N can be read at the earliest at edge N+1.
- STANDARD read latency: rd_en sampled at edge N puts the data on rd_data after edge N, so the consumer uses it during cycle N+1.
- FWFT: the first word appears on rd_data together with empty falling, one cycle after the write edge. A pop at edge N presents the next word after edge N.
- Simultaneous read and write:
  - When full: only the read is accepted; count goes from DEPTH to DEPTH-1.
  - When empty: only the write is accepted; count goes from 0 to 1.
  - Otherwise: both are accepted and count is unchanged.
- Pointer wrap is seamless. Back-to-back throughput is one word per cycle in each direction.

## Configuration
- Macro FIFO_ERR_FLAG_EN.
- Defined: overflow pulses high for one cycle after any edge where wr_en & full. underflow pulses high for one cycle after any edge where rd_en & empty. Both are registered and reset to 0.
- Not defined: overflow and underflow are tied to 0 and the error registers are not built. All other behaviour is identical.

## Test plan
Common setup: ADDR_WIDTH=4, DATA_WIDTH=16, ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2.
- Fill, STANDARD mode: 16 writes of 0x0000..0x000F.
  - almost_empty falls after the 3rd write.
  - almost_full rises after the 14th write.
  - full rises after the 16th write; wr_water_level=16.
  - A 17th write is refused; overflow=1 for one cycle when FIFO_ERR_FLAG_EN is defined.
- Drain, STANDARD mode: 16 reads.
  - rd_data shows 0x0000..0x000F in order, each one cycle after its rd_en.
  - empty rises after the 16th read.
  - A 17th read leaves rd_data=0x000F and pulses underflow.
- FWFT mode: single write of 0xA5A5.
  - One cycle later, empty=0 and rd_data=0xA5A5 with no rd_en.
  - rd_en then sets empty=1 on the next cycle.
- Simultaneous read and write:
  - At count=16, wr_en=rd_en=1 → count=15, head word read, write dropped.
  - At count=0 → count=1, underflow pulse, no rd_data change (STANDARD).
- Wrap: 40 cycles of continuous write+read with count held at 5. The output sequence equals the input delayed by 5 words, and no flag glitches.
- Reset mid-operation: assert rst at count=9, asynchronously between edges.
  - Immediately: empty=1, wr_water_level=0, rd_data=0 (STANDARD).
  - After release, a write of 0x1234 followed by a read returns 0x1234.
